// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Bundles the serial-side inputs and the parallel-side outputs
//               of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 BAUD_CLK;
    logic                 RX;
    logic [DATA_BITS-1:0] DATA;
    logic                 VALID;
    logic                 FRAME_ERR;
    logic                 PAR_ERR;
    logic                 BUSY;

    // Receiver side: consumes the divider tap and line, produces bytes
    modport master (
        input  BAUD_CLK, RX,
        output DATA, VALID, FRAME_ERR, PAR_ERR, BUSY
    );

    modport slave (
        output BAUD_CLK, RX,
        input  DATA, VALID, FRAME_ERR, PAR_ERR, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 UART receiver; define UART_RX_PARITY_EN for
//               8E1 framing with a live parity-error strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    uart_rx_if.master   bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] c_CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] c_CNT_FULL  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] c_BITN_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] c_BITN_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_baud_q;
    logic                 r_rx_meta, r_rx_s;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [BW-1:0]        r_bitn, w_bitn_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 w_tick;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_err, w_par_err_nxt;
    logic                 r_par_bad, w_par_bad_nxt;
`endif

    assign w_tick = bus.BAUD_CLK & ~r_baud_q;

    // Edge detector and line synchronizer; line flops idle high
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_baud_q  <= 1'b0;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_baud_q  <= bus.BAUD_CLK;
            r_rx_meta <= bus.RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bitn_nxt      = r_bitn;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_nxt   = 1'b0;
        w_par_bad_nxt   = r_par_bad;
`endif
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        if (r_rx_s) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_cnt_nxt   = '0;
                            w_bitn_nxt  = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_CNT_FULL) begin
                        w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_cnt_nxt   = '0;
                        w_bitn_nxt  = r_bitn + c_BITN_ONE;
                        if (r_bitn == c_BITN_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == c_CNT_FULL) begin
                        // Even parity: data plus parity bit must hold an even count of ones
                        w_par_bad_nxt = ^{r_shift, r_rx_s};
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == c_CNT_FULL) begin
                        w_cnt_nxt = '0;
                        if (!r_rx_s) begin
                            w_frame_err_nxt = 1'b1;
                            w_state_nxt     = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            w_par_err_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
`endif
                        end else begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bitn      <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
            r_par_bad   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bitn      <= w_bitn_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= w_par_err_nxt;
            r_par_bad   <= w_par_bad_nxt;
`endif
        end
    end

    assign bus.DATA      = r_data;
    assign bus.VALID     = r_valid;
    assign bus.FRAME_ERR = r_frame_err;
    assign bus.BUSY      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.PAR_ERR   = r_par_err;
`else
    assign bus.PAR_ERR   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (16x oversampling,
//               one sample tick every 4 CLK cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TICKS = 16 * 11;
`else
    localparam int FRAME_TICKS = 16 * 10;
`endif

    logic CLK;
    logic RST;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int tick_cnt  = 0;
    int n_valid   = 0;
    int n_ferr    = 0;
    int n_perr    = 0;
    int n_both    = 0;
    int run_len   = 0;
    int max_run   = 0;
    int div       = 0;
    logic [7:0] vdata [16];
    int         vtick [16];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Divider tap: 2 cycles high, 2 low, changing away from the active edge
    initial begin
        bus.BAUD_CLK = 1'b0;
        forever begin
            @(negedge CLK);
            div = (div + 1) % 4;
            bus.BAUD_CLK = (div >= 2);
            if (div == 2) tick_cnt++;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.VALID) begin
                if (n_valid < 16) begin
                    vdata[n_valid] = bus.DATA;
                    vtick[n_valid] = tick_cnt;
                end
                n_valid++;
            end
            if (bus.FRAME_ERR) n_ferr++;
            if (bus.PAR_ERR)   n_perr++;
            if (bus.FRAME_ERR && bus.PAR_ERR) n_both++;
            if (bus.VALID || bus.FRAME_ERR || bus.PAR_ERR) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge bus.BAUD_CLK);
    endtask

    task automatic send_bit(input logic v);
        bus.RX = v;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit === 1'bx) $display("note: parity bit unknown");
`endif
        send_bit(stop_bit);
    endtask

    initial begin
        RST    = 1'b1;
        bus.RX = 1'b1;
        repeat (5) @(negedge CLK);
        check("rst_data",  {24'd0, bus.DATA}, 32'h00);
        check("rst_valid", {31'd0, bus.VALID}, 32'd0);
        check("rst_ferr",  {31'd0, bus.FRAME_ERR}, 32'd0);
        check("rst_perr",  {31'd0, bus.PAR_ERR}, 32'd0);
        check("rst_busy",  {31'd0, bus.BUSY}, 32'd0);
        RST = 1'b0;
        wait_ticks(20);

        // Clean frame
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_ticks(4);
        check("a5_nvalid", n_valid, 1);
        check("a5_data",   {24'd0, bus.DATA}, 32'hA5);
        check("a5_ferr",   n_ferr, 0);
        check("a5_width",  max_run, 1);
        check("a5_busy",   {31'd0, bus.BUSY}, 32'd0);

        // Start-bit glitch
        bus.RX = 1'b0;
        wait_ticks(3);
        bus.RX = 1'b1;
        wait_ticks(30);
        check("gl_nvalid", n_valid, 1);
        check("gl_ferr",   n_ferr, 0);
        check("gl_busy",   {31'd0, bus.BUSY}, 32'd0);
        check("gl_data",   {24'd0, bus.DATA}, 32'hA5);

        // Low stop bit then line stuck low
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_ticks(40);
        check("fe_nferr",  n_ferr, 1);
        check("fe_nvalid", n_valid, 1);
        check("fe_data",   {24'd0, bus.DATA}, 32'hA5);
        check("fe_busy",   {31'd0, bus.BUSY}, 32'd1);
        bus.RX = 1'b1;
        wait_ticks(16);
        check("fe_idle",   {31'd0, bus.BUSY}, 32'd0);
        send_frame(8'h81, 1'b1, ^8'h81);
        wait_ticks(4);
        check("r81_nvalid", n_valid, 2);
        check("r81_data",   {24'd0, bus.DATA}, 32'h81);
        check("r81_nferr",  n_ferr, 1);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        wait_ticks(4);
        check("b2b_nvalid", n_valid, 4);
        check("b2b_d0",     {24'd0, vdata[2]}, 32'h00);
        check("b2b_d1",     {24'd0, vdata[3]}, 32'hFF);
        check("b2b_gap",    vtick[3] - vtick[2], FRAME_TICKS);

        // Reset during data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0 ^ (8'h96 >> i) & 8'h01);
        bus.RX = 1'b1;
        wait_ticks(8);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("mr_busy_rst", {31'd0, bus.BUSY}, 32'd0);
        check("mr_data_rst", {24'd0, bus.DATA}, 32'h00);
        RST = 1'b0;
        wait_ticks(30);
        check("mr_nvalid", n_valid, 4);
        check("mr_nferr",  n_ferr, 1);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        wait_ticks(4);
        check("r5a_nvalid", n_valid, 5);
        check("r5a_data",   {24'd0, bus.DATA}, 32'h5A);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(4);
        check("p_ok_nvalid", n_valid, 6);
        check("p_ok_data",   {24'd0, bus.DATA}, 32'h07);
        check("p_ok_nperr",  n_perr, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_ticks(4);
        check("p_bad_nperr",  n_perr, 1);
        check("p_bad_nvalid", n_valid, 6);
        check("p_bad_nferr",  n_ferr, 1);
`else
        check("np_nperr", n_perr, 0);
`endif
        check("strobe_width", max_run, 1);
        check("strobe_excl",  n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path, sitting directly downstream of the clock divider. It takes the divider's oversampling tap (`BAUD_CLK`) as a level signal in the `CLK` domain, turns its rising edges into sample ticks, and deframes 8N1 (optionally 8E1) asynchronous serial data from the `RX` pin. Each received byte is presented on a parallel bus with a one-cycle valid strobe. Framing and parity errors are flagged.

## Interface
- `OVERSAMPLE`, 16 — sample ticks per bit period; even, ≥4.
- `DATA_BITS`, 8 — data bits per frame, LSB first; 5..8.

- `CLK`  in  1  system clock; only clock in the block.
- `RST`  in  1  synchronous, active-high reset.
- `BAUD_CLK`  in  1  divider tap, square wave synchronous to `CLK`; each 0→1 transition is one sample tick.
- `RX`  in  1  asynchronous serial line, idle high.
- `DATA`  out  `DATA_BITS`  last good byte received; holds between frames.
- `VALID`  out  1  one-`CLK` pulse when `DATA` is updated.
- `FRAME_ERR`  out  1  one-`CLK` pulse when the stop bit is sampled low.
- `PAR_ERR`  out  1  one-`CLK` pulse on parity mismatch; constant 0 without the parity macro.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- Tick generation: register `BAUD_CLK` once into `baud_q`. `tick = BAUD_CLK & ~baud_q`. All bit timing advances only on `tick`.
- `RX` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- Tick counter `cnt`: width `$clog2(OVERSAMPLE)`. Bit counter `bitn`: width `$clog2(DATA_BITS+1)`.
- State machine:
  - IDLE: on tick with `rx_s==0` → START, `cnt=0`.
  - START: count ticks. At `cnt==OVERSAMPLE/2-1`, check `rx_s`.
    - `rx_s==1`: glitch → IDLE, no output.
    - `rx_s==0`: `cnt=0`, `bitn=0` → DATA.
  - DATA: at `cnt==OVERSAMPLE-1`, shift `rx_s` into the MSB of the shift register (right shift, LSB first), `cnt=0`, `bitn++`. After `DATA_BITS` samples → PARITY if enabled, otherwise STOP.
  - PARITY: sample one bit period later, as in DATA. Store the even-parity result → STOP.
  - STOP: sample at `cnt==OVERSAMPLE-1`.
    - `rx_s==1` and parity OK: load `DATA`, pulse `VALID` → IDLE.
    - `rx_s==1` and parity bad: pulse `PAR_ERR`, `DATA` unchanged → IDLE.
    - `rx_s==0`: pulse `FRAME_ERR`, `DATA` unchanged → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1` (break/stuck-low protection) → IDLE.
- Frame-error precedence: `FRAME_ERR` and `PAR_ERR` never pulse together.
- Ticks arriving while in IDLE with `rx_s==1` are ignored. Counters hold when there is no tick.

## Timing
- Reset values: `DATA=0`, `VALID=0`, `FRAME_ERR=0`, `PAR_ERR=0`, `BUSY=0`, state IDLE, counters 0, `baud_q=0`.
- Reset has priority over everything.
- Reset mid-frame aborts the frame with no strobe. The next start bit is accepted on the first tick after `RST` deasserts.
- `RX` latency: 2 `CLK` cycles through the synchronizer before the state machine sees it.
- `VALID`, `FRAME_ERR` and `PAR_ERR` are registered. Each goes high on the `CLK` edge following the tick that samples the stop bit, and stays high for exactly one cycle.
- `DATA` changes on the same edge `VALID` rises.
- Back-to-back frames: IDLE accepts a new start bit on the first tick after STOP. No idle bit is required.
- Data bits are sampled mid-bit, i.e. `OVERSAMPLE/2 + k·OVERSAMPLE` ticks after the start edge is detected.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is start + `DATA_BITS` + even parity + stop.
  - PARITY state is compiled in.
  - `PAR_ERR` is live.
- Macro undefined:
  - Frame is 8N1 (start + `DATA_BITS` + stop).
  - PARITY state is absent.
  - `PAR_ERR` is tied to 0.

## Test plan
- Default parameters, one clean frame of 0xA5 (16 ticks per bit) → `DATA=0xA5`, `VALID` high for exactly 1 `CLK`, `FRAME_ERR=0`, `BUSY` low afterwards.
- `RX` low for 3 ticks, then high → no `VALID` or `FRAME_ERR`; FSM returns to IDLE; `DATA` unchanged.
- 0x3C sent with the stop bit driven low, then `RX` held low for 40 ticks, then 0x81 sent → `FRAME_ERR` pulses once, `DATA` stays 0x3C's predecessor, then `DATA=0x81` with `VALID`.
- Back-to-back 0x00 then 0xFF with no idle gap → two `VALID` pulses, 160 ticks apart; `DATA` = 0x00, then 0xFF.
- `RST` asserted during bit 4 of a frame, then 0x5A sent → no strobe for the aborted frame, `DATA=0x5A` with `VALID` afterwards.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 1 → `VALID`, `DATA=0x07`. Send 0x07 with parity bit 0 → `PAR_ERR` pulse and no `VALID`.
